// File: rtl/opsum_pkg.sv
// rtl/opsum_pkg.sv - shared constants and types for the output-psum write-back buffer
// Purpose: array geometry, FSM state type and word-packing constants.
// Ports: none (package).
package opsum_pkg;

  localparam int ROW_NUM  = 32;               // PE rows, one store per row
  localparam int DEPTH    = 4;                // entries per row store
  localparam int LANE_W   = 16;               // one psum entry
  localparam int BEAT_NUM = 2;                // GLB words per row
  localparam int WORD_W   = LANE_W * BEAT_NUM; // one GLB word carries two entries

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/opsum_row_store.sv
// rtl/opsum_row_store.sv - one row's 4x16 psum store with beat-select read
// Purpose: holds the psums captured for a single PE row until they are drained.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears all entries)
//   clear       - synchronous clear of all entries
//   wr_en       - write wr_data into entry wr_idx
//   wr_idx      - entry index 0..3 (0 = oldest capture)
//   wr_data     - 16-bit psum
//   beat        - 0 selects {entry1, entry0}, 1 selects {entry3, entry2}
//   word        - 32-bit packed read word
module opsum_row_store
  import opsum_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [1:0]        wr_idx,
  input  logic [LANE_W-1:0] wr_data,
  input  logic              beat,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Older entry sits in the low half so the GLB can replay words unchanged.
  always_comb begin
    word = beat ? {mem[3], mem[2]} : {mem[1], mem[0]};
  end

endmodule

// File: rtl/opsum_buffer.sv
// rtl/opsum_buffer.sv - output-psum write-back buffer between Reducer and GLB
// Purpose: captures one psum per row per strobe into per-row stores, then drains
// them to the GLB as 32-bit words, two words per active row.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   opsum_in     - ROW_NUM x 16-bit psums, row r at [r*16 +: 16]
//   opsum_in_f   - capture strobe for all rows
//   flush        - drain a partially filled buffer
//   row_en       - active row count (0 or >ROW_NUM means ROW_NUM), latched on drain entry
//   buf_ready    - capture will be accepted
//   valid_op     - word valid toward GLB
//   ready_op     - GLB accepts word
//   opsum_out    - packed word toward GLB
//   done         - one-cycle pulse after the final drain handshake
//   ovf_err      - sticky: strobe seen while draining
module opsum_buffer #(
  parameter int ROW_NUM = opsum_pkg::ROW_NUM,
  parameter int DEPTH   = opsum_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ROW_NUM*16-1:0] opsum_in,
  input  logic                  opsum_in_f,
  input  logic                  flush,
  input  logic [5:0]            row_en,
  output logic                  buf_ready,
  output logic                  valid_op,
  input  logic                  ready_op,
  output logic [31:0]           opsum_out,
  output logic                  done,
  output logic                  ovf_err
);

  import opsum_pkg::state_t;
  import opsum_pkg::FILL;
  import opsum_pkg::DRAIN;
  import opsum_pkg::LANE_W;

  localparam int IDX_W = $clog2(ROW_NUM);

  state_t           state, state_next;
  logic [2:0]       fill_cnt;
  logic [IDX_W-1:0] row_idx;
  logic             beat;
  logic [5:0]       rows;
  logic [5:0]       rows_clamped;

  logic             capture;
  logic             go_drain;
  logic             handshake;
  logic             drain_done;

  logic [31:0]      words [ROW_NUM];

  // ---------------------------------------------------------------- control
  always_comb begin
    capture    = opsum_in_f && (state == FILL);
    // A flush counts a same-cycle capture, so a lone flush on an empty buffer is ignored.
    go_drain   = (state == FILL) &&
                 ((capture && (fill_cnt == 3'(DEPTH - 1))) ||
                  (flush && ((fill_cnt != 3'd0) || capture)));
    handshake  = (state == DRAIN) && ready_op;
    drain_done = handshake && beat && ({1'b0, row_idx} == (rows - 6'd1));
    rows_clamped = ((row_en == 6'd0) || (row_en > 6'(ROW_NUM))) ? 6'(ROW_NUM) : row_en;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (go_drain)   state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    buf_ready = (state == FILL);
    valid_op  = (state == DRAIN);
    opsum_out = valid_op ? words[row_idx] : 32'd0;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
      row_idx  <= '0;
      beat     <= 1'b0;
      rows     <= 6'(ROW_NUM);
      done     <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      done <= drain_done;
      if (opsum_in_f && (state == DRAIN)) begin
        ovf_err <= 1'b1;
      end
      if (state == FILL) begin
        if (capture) begin
          fill_cnt <= fill_cnt + 3'd1;
        end
        if (go_drain) begin
          rows    <= rows_clamped;
          row_idx <= '0;
          beat    <= 1'b0;
        end
      end else if (handshake) begin
        if (drain_done) begin
          fill_cnt <= '0;
          row_idx  <= '0;
          beat     <= 1'b0;
        end else begin
          beat <= ~beat;
          if (beat) begin
            row_idx <= row_idx + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- row stores
  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    opsum_row_store u_store (
      .clk     (clk),
      .reset   (reset),
      .clear   (drain_done),
      .wr_en   (capture),
      .wr_idx  (fill_cnt[1:0]),
      .wr_data (opsum_in[r*LANE_W +: LANE_W]),
      .beat    (beat),
      .word    (words[r])
    );
  end

endmodule
